// File: rtl/debounce_scheduler_if.sv
// Change-event stream of the debounce scheduler: valid/ready handshake with channel and level fields.
interface debounce_scheduler_if #(
  parameter int CH_BITS = 3
) ();
  logic               evt_valid;
  logic               evt_ready;
  logic [CH_BITS-1:0] evt_channel;
  logic               evt_level;

  modport master (
    output evt_valid,
    output evt_channel,
    output evt_level,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_channel,
    input  evt_level,
    output evt_ready
  );
endinterface

// File: rtl/debounce_scheduler.sv
// Round-robin debounce controller: one shared compare/increment datapath over per-channel counters.
// Optional DEBOUNCE_SCHED_INVERT_EN adds a per-channel invert input applied before the filter.
//
// state | meaning
// IDLE  | enable low, scan frozen
// SCAN  | one channel visited per clk, ptr advances
// HOLD  | event pending and not accepted, scan stalled
module debounce_scheduler #(
  parameter int CHANNELS = 8,
  parameter int WIDTH    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] din,
`ifdef DEBOUNCE_SCHED_INVERT_EN
  input  logic [CHANNELS-1:0] invert,
`endif
  input  logic                enable,
  input  logic [WIDTH-1:0]    period,
  output logic [CHANNELS-1:0] dout,
  debounce_scheduler_if.master evt,
  output logic                scan_wrap
);

  localparam int CH_BITS = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [CH_BITS-1:0] LAST_PTR = CH_BITS'(CHANNELS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CHANNELS-1:0] sync1_q, sync2_q;
  logic [CHANNELS-1:0] level;
  logic [CHANNELS-1:0] dout_q, dout_d;
  logic [WIDTH-1:0]    cnt_q [CHANNELS];
  logic [WIDTH-1:0]    cnt_d [CHANNELS];
  logic [CH_BITS-1:0]  ptr_q, ptr_d;
  logic                evt_valid_q, evt_valid_d;
  logic [CH_BITS-1:0]  evt_channel_q, evt_channel_d;
  logic                evt_level_q, evt_level_d;
  logic                scan_wrap_q, scan_wrap_d;
  logic                stall;
  logic                visit;
  logic                cur_lvl;
  logic [WIDTH-1:0]    cur_cnt;

`ifdef DEBOUNCE_SCHED_INVERT_EN
  assign level = sync2_q ^ invert;
`else
  assign level = sync2_q;
`endif

  // An unaccepted event blocks the visit in the same clk so a second toggle can never overwrite it.
  assign stall = evt_valid_q && !evt.evt_ready;
  assign visit = (state_q == SCAN) && enable && !stall;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (enable) state_d = SCAN;
      SCAN: begin
        if (!enable)    state_d = IDLE;
        else if (stall) state_d = HOLD;
      end
      HOLD: if (evt.evt_ready) state_d = enable ? SCAN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    dout_d        = dout_q;
    cnt_d         = cnt_q;
    ptr_d         = ptr_q;
    evt_valid_d   = evt_valid_q && !evt.evt_ready;
    evt_channel_d = evt_channel_q;
    evt_level_d   = evt_level_q;
    scan_wrap_d   = 1'b0;
    cur_lvl       = level[ptr_q];
    cur_cnt       = cnt_q[ptr_q];
    if (visit) begin
      ptr_d       = (ptr_q == LAST_PTR) ? '0 : ptr_q + 1'b1;
      scan_wrap_d = (ptr_q == LAST_PTR);
      if (cur_lvl == dout_q[ptr_q]) begin
        cnt_d[ptr_q] = '0;
      end else if (cur_cnt >= period) begin
        dout_d[ptr_q] = cur_lvl;
        cnt_d[ptr_q]  = '0;
        evt_valid_d   = 1'b1;
        evt_channel_d = ptr_q;
        evt_level_d   = cur_lvl;
      end else if (cur_cnt != '1) begin
        cnt_d[ptr_q] = cur_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      sync1_q       <= '0;
      sync2_q       <= '0;
      dout_q        <= '0;
      ptr_q         <= '0;
      evt_valid_q   <= 1'b0;
      evt_channel_q <= '0;
      evt_level_q   <= 1'b0;
      scan_wrap_q   <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) cnt_q[i] <= '0;
    end else begin
      state_q       <= state_d;
      sync1_q       <= din;
      sync2_q       <= sync1_q;
      dout_q        <= dout_d;
      ptr_q         <= ptr_d;
      evt_valid_q   <= evt_valid_d;
      evt_channel_q <= evt_channel_d;
      evt_level_q   <= evt_level_d;
      scan_wrap_q   <= scan_wrap_d;
      for (int i = 0; i < CHANNELS; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign dout            = dout_q;
  assign scan_wrap       = scan_wrap_q;
  assign evt.evt_valid   = evt_valid_q;
  assign evt.evt_channel = evt_channel_q;
  assign evt.evt_level   = evt_level_q;

endmodule

// File: tb/tb_debounce_scheduler.sv
// Directed bench for debounce_scheduler with CHANNELS=4, WIDTH=8.
module tb_debounce_scheduler;
  localparam int CH = 4;
  localparam int W  = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [CH-1:0] din;
  logic          enable;
  logic [W-1:0]  period;
  logic [CH-1:0] dout;
  logic          scan_wrap;

  debounce_scheduler_if #(.CH_BITS(2)) evt_if ();

  debounce_scheduler #(.CHANNELS(CH), .WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .enable    (enable),
    .period    (period),
    .dout      (dout),
    .evt       (evt_if),
    .scan_wrap (scan_wrap)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] ch;
    logic       lvl;
  } ev_t;

  ev_t evq[$];
  int  wrap_total = 0;
  int  total = 0;
  int  bad = 0;

  // Accepted events and wrap pulses, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (evt_if.evt_valid && evt_if.evt_ready)
        evq.push_back({evt_if.evt_channel, evt_if.evt_level});
      if (scan_wrap) wrap_total++;
    end
  end

  typedef struct {
    logic [3:0] din;
    logic       en;
    logic [7:0] per;
    int         ncyc;
    logic [3:0] exp_dout;
    int         exp_nevt;
    int         exp_wraps;
    bit         chk_last;
    logic [1:0] last_ch;
    logic       last_lvl;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_wrap();
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      if (scan_wrap) seen = 1'b1;
    end
    check("wrap_seen", seen, 1);
  endtask

  task automatic glitch(input int hold);
    int n0;
    wait_wrap();
    n0 = evq.size();
    din[1] = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      step();
      if (k == hold) din[1] = 1'b0;
    end
    check("glitch_dout", dout, 4'h4);
    check("glitch_nevt", evq.size() - n0, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, w0;

    vecs[0] = '{4'h0, 1'b1, 8'd3, 30, 4'h0, 4, -1, 1'b0, 2'd0, 1'b0};
    vecs[1] = '{4'h5, 1'b1, 8'd1, 30, 4'h5, 2, -1, 1'b0, 2'd0, 1'b0};
    vecs[2] = '{4'hA, 1'b1, 8'd0, 20, 4'hA, 4, -1, 1'b0, 2'd0, 1'b0};
    vecs[3] = '{4'hB, 1'b1, 8'd2, 30, 4'hB, 1, -1, 1'b1, 2'd0, 1'b1};
    vecs[4] = '{4'h0, 1'b0, 8'd3, 30, 4'hB, 0,  0, 1'b0, 2'd0, 1'b0};
    vecs[5] = '{4'h0, 1'b1, 8'd3, 40, 4'h0, 3, -1, 1'b0, 2'd0, 1'b0};
    vecs[6] = '{4'h0, 1'b1, 8'd3, 20, 4'h0, 0, -1, 1'b0, 2'd0, 1'b0};

    // Reset with inputs high, then start scanning once the synchronizer has settled.
    rst_n = 1'b0;
    din = 4'hF;
    enable = 1'b0;
    period = 8'd3;
    evt_if.evt_ready = 1'b1;
    for (int k = 0; k < 3; k++) step();
    check("rst_dout", dout, 4'h0);
    check("rst_valid", evt_if.evt_valid, 0);
    check("rst_wrap", scan_wrap, 0);
    check("rst_ch", evt_if.evt_channel, 0);
    check("rst_lvl", evt_if.evt_level, 0);
    #3 rst_n = 1'b1;
    for (int k = 0; k < 3; k++) step();
    enable = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      step();
      if (k == 13) check("t1_dout_pre", dout, 4'h0);
      if (k == 14) check("t1_dout_first", dout, 4'h1);
    end
    check("t1_dout", dout, 4'hF);
    check("t1_nevt", evq.size(), 4);
    for (int i = 0; i < 4 && i < evq.size(); i++) begin
      check("t1_ev_ch", evq[i].ch, i);
      check("t1_ev_lvl", evq[i].lvl, 1);
    end

    for (int i = 0; i < 7; i++) begin
      din = vecs[i].din;
      enable = vecs[i].en;
      period = vecs[i].per;
      n0 = evq.size();
      step();
      w0 = wrap_total;
      for (int c = 1; c < vecs[i].ncyc; c++) step();
      check("vec_dout", dout, vecs[i].exp_dout);
      check("vec_nevt", evq.size() - n0, vecs[i].exp_nevt);
      if (vecs[i].exp_wraps >= 0) check("vec_wraps", wrap_total - w0, vecs[i].exp_wraps);
      if (vecs[i].chk_last && evq.size() > 0) begin
        check("vec_last_ch", evq[$].ch, vecs[i].last_ch);
        check("vec_last_lvl", evq[$].lvl, vecs[i].last_lvl);
      end
    end

    // Rising edge on ch2: toggle on the 4th mismatching visit, wrap every 4 clks.
    wait_wrap();
    n0 = evq.size();
    din[2] = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      step();
      check("t2_wrap", scan_wrap, (k % 4) == 0);
      check("t2_dout2", dout[2], k >= 15);
      if (k == 15) begin
        check("t2_valid", evt_if.evt_valid, 1);
        check("t2_ch", evt_if.evt_channel, 2);
        check("t2_lvl", evt_if.evt_level, 1);
      end
    end
    for (int k = 0; k < 3; k++) step();
    check("t2_nevt", evq.size() - n0, 1);

    // Two-visit glitch, then a three-visit glitch that would toggle if the count had not cleared.
    glitch(8);
    glitch(12);

    // Back-pressure: ch0 held in HOLD, ch3 follows once accepted.
    wait_wrap();
    n0 = evq.size();
    for (int k = 1; k <= 31; k++) begin
      step();
      if (k == 2) begin
        din = 4'hD;
        evt_if.evt_ready = 1'b0;
      end
      if (k >= 17 && k <= 27) begin
        check("t4_hold_valid", evt_if.evt_valid, 1);
        check("t4_hold_ch", evt_if.evt_channel, 0);
        check("t4_hold_lvl", evt_if.evt_level, 1);
        check("t4_hold_wrap", scan_wrap, 0);
        check("t4_hold_dout", dout, 4'h5);
      end
      if (k == 27) evt_if.evt_ready = 1'b1;
      if (k >= 28 && k <= 30) check("t4_gap_valid", evt_if.evt_valid, 0);
      if (k == 31) begin
        check("t4_ch3_valid", evt_if.evt_valid, 1);
        check("t4_ch3_ch", evt_if.evt_channel, 3);
        check("t4_ch3_lvl", evt_if.evt_level, 1);
      end
    end
    step();
    step();
    check("t4_nevt", evq.size() - n0, 2);
    if (evq.size() >= 2) begin
      check("t4_ev0", evq[$-1], {2'd0, 1'b1});
      check("t4_ev1", evq[$], {2'd3, 1'b1});
    end
    check("t4_dout", dout, 4'hD);

    // period=0: the first visit after sync follows the input.
    wait_wrap();
    din = 4'hF;
    period = 8'd0;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k == 5) check("t5_rise_pre", dout, 4'hD);
      if (k == 6) check("t5_rise", dout, 4'hF);
    end
    wait_wrap();
    din = 4'hD;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k == 5) check("t5_fall_pre", dout, 4'hF);
      if (k == 6) check("t5_fall", dout, 4'hD);
    end

    period = 8'd3;
    din = 4'h0;
    for (int k = 0; k < 40; k++) step();
    check("clr_dout", dout, 4'h0);

    // Reset mid-count on ch2, then the full filter must run again.
    wait_wrap();
    din = 4'h4;
    for (int k = 1; k <= 8; k++) step();
    #3 rst_n = 1'b0;
    #1;
    check("t6_dout", dout, 4'h0);
    check("t6_valid", evt_if.evt_valid, 0);
    check("t6_wrap", scan_wrap, 0);
    check("t6_ch", evt_if.evt_channel, 0);
    check("t6_lvl", evt_if.evt_level, 0);
    @(posedge clk);
    @(posedge clk);
    #4 rst_n = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step();
      check("t6_refilter", dout, (k >= 16) ? 4'h4 : 4'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
